// File: rtl/asic_ioring_pkg.sv
// rtl/asic_ioring_pkg.sv - shared state codes and ring layout for the padring power sequencer
package asic_ioring_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_OFF   = 3'd0;
  localparam state_t ST_ISO   = 3'd1;
  localparam state_t ST_UP    = 3'd2;
  localparam state_t ST_DEISO = 3'd3;
  localparam state_t ST_ON    = 3'd4;
  localparam state_t ST_DOWN  = 3'd5;

  localparam int EN_BASE = 0;
  localparam int TO_OFS  = 4;

  // Isolation sits directly above the group enables.
  function automatic int iso_bit(input int ngrp);
    return ngrp;
  endfunction

endpackage

// File: rtl/asic_iosync.sv
// rtl/asic_iosync.sv - two-flop synchroniser, async active-high reset to 0
module asic_iosync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/asic_ioring_seq.sv
// rtl/asic_ioring_seq.sv - padring pad-group power sequencer, one per side
// Optional group-ready wait with sticky timeout: ASIC_IORING_SEQ_TIMEOUT_EN
import asic_ioring_pkg::*;

module asic_ioring_seq #(
  parameter int         NCTRL = 8,
  parameter int         NGRP  = 4,
  parameter int         DLYW  = 8,
  parameter logic [7:0] DIR   = "N"
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwrgood,
  input  logic             pwr_req,
  output logic             pwr_ack,
  input  logic [DLYW-1:0]  dly,
  input  logic [NGRP-1:0]  grp_ok,
  output logic             busy,
  output logic             err,
  output logic [NCTRL-1:0] ctrlring
);

  localparam int IDXW = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NGRP - 1);

  if (NCTRL < NGRP + 1) begin : g_nctrl_chk
    $error("asic_ioring_seq: NCTRL must be >= NGRP+1");
  end

  state_t           state;
  logic [DLYW-1:0]  cnt;
  logic [IDXW-1:0]  idx;
  logic [NGRP-1:0]  en;
  logic             iso;
  logic             ack;
  logic             pg_s;
  logic             cnt_zero;
  logic             stage_done;
  logic             to_ovf;
  logic             active;
  logic             abort;
  logic             unused_cfg;

  asic_iosync u_pg_sync (
    .clk (clk),
    .rst (reset),
    .d   (pwrgood),
    .q   (pg_s)
  );

  assign cnt_zero = (cnt == '0);
  assign active   = (state == ST_ISO) || (state == ST_UP) ||
                    (state == ST_DEISO) || (state == ST_ON);
  assign abort    = active && (!pwr_req || to_ovf);

`ifdef ASIC_IORING_SEQ_TIMEOUT_EN
  logic [DLYW+TO_OFS-1:0] tcnt;
  logic                   err_q;

  assign stage_done = cnt_zero && grp_ok[idx];
  assign to_ovf     = (state == ST_UP) && (&tcnt) && !stage_done;
  assign err        = err_q;
  assign unused_cfg = ^DIR;

  // Wait timer restarts at every UP stage; err survives everything but reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (pg_s && to_ovf)
        err_q <= 1'b1;
      if (pg_s && (state == ST_UP) && !stage_done)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;
    end
  end
`else
  assign stage_done = cnt_zero;
  assign to_ovf     = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = ^{DIR, grp_ok};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_OFF;
      cnt   <= '0;
      idx   <= '0;
      en    <= '0;
      iso   <= 1'b1;
      ack   <= 1'b0;
    end else if (!pg_s) begin
      state <= ST_OFF;
      cnt   <= '0;
      idx   <= '0;
      en    <= '0;
      iso   <= 1'b1;
      ack   <= 1'b0;
    end else if (abort) begin
      // Unwind starts by dropping the group currently being worked on.
      state   <= ST_DOWN;
      cnt     <= dly;
      iso     <= 1'b1;
      ack     <= 1'b0;
      en[idx] <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          if (pwr_req) begin
            state <= ST_ISO;
            cnt   <= dly;
          end
        end
        ST_ISO: begin
          if (cnt_zero) begin
            state <= ST_UP;
            idx   <= '0;
            en[0] <= 1'b1;
            cnt   <= dly;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_UP: begin
          if (stage_done) begin
            cnt <= dly;
            if (idx == LAST) begin
              state <= ST_DEISO;
            end else begin
              idx            <= idx + 1'b1;
              en[idx + 1'b1] <= 1'b1;
            end
          end else if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DEISO: begin
          if (cnt_zero) begin
            state <= ST_ON;
            iso   <= 1'b0;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ON: begin
        end
        ST_DOWN: begin
          if (cnt_zero) begin
            if (idx == '0) begin
              state <= ST_OFF;
            end else begin
              idx            <= idx - 1'b1;
              en[idx - 1'b1] <= 1'b0;
              cnt            <= dly;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

  assign pwr_ack = ack;
  assign busy    = (state != ST_OFF) && (state != ST_ON);

  always_comb begin
    ctrlring                  = '0;
    ctrlring[EN_BASE +: NGRP] = en;
    ctrlring[iso_bit(NGRP)]   = iso;
  end

  a_iso_on_change : assert property (@(posedge clk) disable iff (reset)
    $changed(en) |-> iso);
  a_up_monotonic : assert property (@(posedge clk) disable iff (reset)
    (state == ST_UP && $past(state) == ST_UP) |-> ((en & $past(en)) == $past(en)));
  a_down_monotonic : assert property (@(posedge clk) disable iff (reset)
    (state == ST_DOWN && $past(state) == ST_DOWN) |-> ((en & ~$past(en)) == '0));

endmodule

// File: tb/tb_asic_ioring_seq.sv
// tb/tb_asic_ioring_seq.sv - scoreboard bench for asic_ioring_seq
module tb_asic_ioring_seq;

  localparam int NCTRL = 8;
  localparam int NGRP  = 4;
  localparam int DLYW  = 4;

  typedef struct {
    int          t;
    logic [10:0] v;
  } ev_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             pwrgood;
  logic             pwr_req;
  logic             pwr_ack;
  logic [DLYW-1:0]  dly;
  logic [NGRP-1:0]  grp_ok;
  logic             busy;
  logic             err;
  logic [NCTRL-1:0] ctrlring;

  ev_t         exp_q[$];
  ev_t         ev_cur;
  logic [10:0] last_v;
  logic [10:0] prev_obs;
  logic [10:0] obs;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          err_m = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {err, busy, pwr_ack, ctrlring};

  asic_ioring_seq #(.NCTRL(NCTRL), .NGRP(NGRP), .DLYW(DLYW), .DIR("N")) dut (
    .clk      (clk),
    .reset    (reset),
    .pwrgood  (pwrgood),
    .pwr_req  (pwr_req),
    .pwr_ack  (pwr_ack),
    .dly      (dly),
    .grp_ok   (grp_ok),
    .busy     (busy),
    .err      (err),
    .ctrlring (ctrlring)
  );

  // Observable tuple: {err, busy, ack, ring} with n low groups enabled.
  function automatic logic [10:0] tup(bit e, bit b, bit a, int n, bit i);
    logic [7:0] r;
    r       = 8'((1 << n) - 1);
    r[NGRP] = i;
    return {e, b, a, r};
  endfunction

  function automatic void push(int t, logic [10:0] v);
    ev_t e;
    if (v !== last_v) begin
      e.t = t;
      e.v = v;
      exp_q.push_back(e);
      last_v = v;
    end
  endfunction

  // Power-up from ISO entry at T; only events strictly before A happen.
  function automatic void plan_up(int t0, int a, int l);
    push(t0, tup(err_m, 1, 0, 0, 1));
    for (int k = 0; k < NGRP; k++)
      if (t0 + l * (k + 1) < a) push(t0 + l * (k + 1), tup(err_m, 1, 0, k + 1, 1));
    if (t0 + l * (NGRP + 2) < a) push(t0 + l * (NGRP + 2), tup(err_m, 0, 1, NGRP, 0));
  endfunction

  function automatic int idx_at(int t0, int a, int l);
    int n;
    n = (a - t0 - 1) / l;
    if (n > NGRP) n = NGRP;
    return (n > 0) ? n - 1 : 0;
  endfunction

  // Staged power-down from group i starting at A; returns the cycle OFF is reached.
  function automatic int unwind(int a, int i, int l);
    push(a, tup(err_m, 1, 0, i, 1));
    for (int j = 1; j <= i; j++) push(a + l * j, tup(err_m, 1, 0, i - j, 1));
    push(a + l * (i + 1), tup(err_m, 0, 0, 0, 1));
    return a + l * (i + 1);
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [10:0] got, logic [10:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (obs !== prev_obs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: cyc %0d got %h want no change", cyc, obs);
        end else begin
          ev_cur = exp_q.pop_front();
          if (ev_cur.t != cyc || ev_cur.v !== obs) begin
            errors++;
            $display("FAIL event: got cyc %0d val %h want cyc %0d val %h",
                     cyc, obs, ev_cur.t, ev_cur.v);
          end
        end
        prev_obs = obs;
      end
    end
  endtask

  task automatic run_seq(int du, int hold, int dd, bit bounce, int rhold);
    int t0, a, l, ld, o, rc;
    l       = du + 1;
    dly     = DLYW'(du);
    pwr_req = 1'b1;
    t0      = cyc + 1;
    a       = t0 + hold;
    ld      = (a - 1 >= t0 + l * (NGRP + 2)) ? dd + 1 : l;
    plan_up(t0, a, l);
    o = unwind(a, idx_at(t0, a, l), ld);
    tick(a - 1 - cyc);
    dly     = DLYW'(ld - 1);
    pwr_req = 1'b0;
    if (bounce) begin
      rc = a + int'($urandom_range(0, o - a));
      tick(rc - cyc);
      pwr_req = 1'b1;
      t0 = o + 1;
      a  = t0 + rhold;
      plan_up(t0, a, ld);
      o = unwind(a, idx_at(t0, a, ld), ld);
      tick(a - 1 - cyc);
      pwr_req = 1'b0;
    end
    tick(o + 2 - cyc);
  endtask

  initial begin
    int t0, a, o, c, p, du;
    reset   = 1'b1;
    pwrgood = 1'b1;
    pwr_req = 1'b0;
    dly     = '0;
    grp_ok  = '1;
    #1;
    check("reset_state", obs, tup(0, 0, 0, 0, 1));
    tick(2);
    reset = 1'b0;
    tick(3);
    prev_obs = obs;
    last_v   = tup(0, 0, 0, 0, 1);
    fork
      monitor_loop();
    join_none

    // Full power-up at dly=3, power-down from ON at dly=1.
    run_seq(3, 27, 1, 1'b0, 1);
    // Abort during UP right after enable[1].
    run_seq(3, 10, 3, 1'b0, 1);

    for (int it = 0; it < 14; it++) begin
`ifndef ASIC_IORING_SEQ_TIMEOUT_EN
      grp_ok = NGRP'($urandom);
`endif
      du = int'($urandom_range(0, 4));
      run_seq(du, int'($urandom_range(1, (du + 1) * (NGRP + 2) + 4)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              int'($urandom_range(1, 30)));
    end

    // pwrgood loss in UP idx1, timed to collide with enable[2].
    dly     = 4'd2;
    pwr_req = 1'b1;
    t0      = cyc + 1;
    c       = t0 + 6;
    p       = c + 3;
    plan_up(t0, p, 3);
    push(p, tup(err_m, 0, 0, 0, 1));
    tick(c - cyc);
    pwrgood = 1'b0;
    tick(p - cyc);
    pwr_req = 1'b0;
    tick(2);
    pwrgood = 1'b1;
    tick(5);

`ifdef ASIC_IORING_SEQ_TIMEOUT_EN
    // grp_ok[2] stuck low: timeout in UP idx2, unwind, err sticky.
    grp_ok  = 4'b1011;
    dly     = 4'd1;
    pwr_req = 1'b1;
    t0      = cyc + 1;
    a       = t0 + 3 * 2 + 256;
    plan_up(t0, t0 + 3 * 2 + 1, 2);
    err_m = 1'b1;
    o = unwind(a, 2, 2);
    tick(a - cyc);
    pwr_req = 1'b0;
    tick(o + 4 - cyc);
    grp_ok = '1;
`endif

    // Async reset mid-DEISO, then dly=0 power-up.
    dly     = 4'd2;
    pwr_req = 1'b1;
    t0      = cyc + 1;
    c       = t0 + 3 * (NGRP + 1) + 1;
    plan_up(t0, c + 1, 3);
    err_m = 1'b0;
    push(c, tup(0, 0, 0, 0, 1));
    tick(c - cyc);
    reset = 1'b1;
    #1;
    check("async_reset", obs, tup(0, 0, 0, 0, 1));
    tick(2);
    dly   = '0;
    reset = 1'b0;
    t0    = cyc + 3;
    a     = t0 + (NGRP + 2) + 3;
    plan_up(t0, a, 1);
    o = unwind(a, idx_at(t0, a, 1), 1);
    tick(a - 1 - cyc);
    pwr_req = 1'b0;
    tick(o + 4 - cyc);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
